// File: rtl/stage3_fast_type_sel_pipe.sv
// Per-lane N-type selector with a registered valid/ready output stage and a 2-entry skid buffer.
// Define FAST_TYPE_SEL_STATS_EN to add the per-lane miss and stall counters.
module stage3_fast_type_sel_pipe #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned NUM_TYPES = 5,
  parameter int unsigned MSG_BITS  = 64,
  parameter int unsigned LEN_BITS  = 4,
  parameter int unsigned CTRL_W    = 3,
  parameter logic [NUM_TYPES*CTRL_W-1:0] TYPE_CODES = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter logic [MSG_BITS-1:0] DEF_MSG = '0,
  parameter logic [LEN_BITS-1:0] DEF_LEN = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CH*NUM_TYPES*MSG_BITS-1:0]   in_msg,
  input  logic [NUM_CH*NUM_TYPES*LEN_BITS-1:0]   in_len,
  input  logic [NUM_CH*CTRL_W-1:0]               in_ctrl,
  input  logic [NUM_CH-1:0]                      in_valid,
  output logic [NUM_CH-1:0]                      in_ready,
  output logic [NUM_CH*MSG_BITS-1:0]             out_msg,
  output logic [NUM_CH*LEN_BITS-1:0]             out_len,
  output logic [NUM_CH-1:0]                      out_miss,
  output logic [NUM_CH-1:0]                      out_valid,
  input  logic [NUM_CH-1:0]                      out_ready
`ifdef FAST_TYPE_SEL_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]                   stat_miss_cnt,
  output logic [NUM_CH*16-1:0]                   stat_stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} lane_state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic [MSG_BITS-1:0] sel_msg, main_msg, skid_msg;
    logic [LEN_BITS-1:0] sel_len, main_len, skid_len;
    logic                sel_miss, main_miss, skid_miss;
    logic                main_valid, rdy, accept, drain;
    lane_state_e         state;

    // Lowest matching type index wins; the miss flag doubles as "not yet matched".
    always_comb begin
      sel_msg  = DEF_MSG;
      sel_len  = DEF_LEN;
      sel_miss = 1'b1;
      for (int unsigned t = 0; t < NUM_TYPES; t++) begin
        if (sel_miss &&
            in_ctrl[c*CTRL_W +: CTRL_W] == TYPE_CODES[t*CTRL_W +: CTRL_W]) begin
          sel_msg  = in_msg[(c*NUM_TYPES+t)*MSG_BITS +: MSG_BITS];
          sel_len  = in_len[(c*NUM_TYPES+t)*LEN_BITS +: LEN_BITS];
          sel_miss = 1'b0;
        end
      end
    end

    assign accept = in_valid[c] & rdy;
    assign drain  = main_valid & out_ready[c];

    always_ff @(posedge clk) begin
      if (rst) begin
        state      <= EMPTY;
        main_valid <= 1'b0;
        rdy        <= 1'b1;
        main_msg   <= DEF_MSG;
        main_len   <= DEF_LEN;
        main_miss  <= 1'b0;
        skid_msg   <= DEF_MSG;
        skid_len   <= DEF_LEN;
        skid_miss  <= 1'b0;
      end else begin
        case (state)
          EMPTY: if (accept) begin
            main_msg   <= sel_msg;
            main_len   <= sel_len;
            main_miss  <= sel_miss;
            main_valid <= 1'b1;
            state      <= ONE;
          end
          ONE: begin
            if (accept && drain) begin
              main_msg  <= sel_msg;
              main_len  <= sel_len;
              main_miss <= sel_miss;
            end else if (accept) begin
              skid_msg  <= sel_msg;
              skid_len  <= sel_len;
              skid_miss <= sel_miss;
              rdy       <= 1'b0;
              state     <= FULL;
            end else if (drain) begin
              main_valid <= 1'b0;
              state      <= EMPTY;
            end
          end
          FULL: if (drain) begin
            main_msg  <= skid_msg;
            main_len  <= skid_len;
            main_miss <= skid_miss;
            rdy       <= 1'b1;
            state     <= ONE;
          end
          default: begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            rdy        <= 1'b1;
          end
        endcase
      end
    end

    assign in_ready[c]                       = rdy;
    assign out_valid[c]                      = main_valid;
    assign out_msg[c*MSG_BITS +: MSG_BITS]   = main_msg;
    assign out_len[c*LEN_BITS +: LEN_BITS]   = main_len;
    assign out_miss[c]                       = main_miss;

`ifdef FAST_TYPE_SEL_STATS_EN
    logic [15:0] miss_cnt, stall_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        miss_cnt  <= '0;
        stall_cnt <= '0;
      end else begin
        if (accept && sel_miss && miss_cnt != '1)
          miss_cnt <= miss_cnt + 16'd1;
        if (main_valid && !out_ready[c] && stall_cnt != '1)
          stall_cnt <= stall_cnt + 16'd1;
      end
    end

    assign stat_miss_cnt[c*16 +: 16]  = miss_cnt;
    assign stat_stall_cnt[c*16 +: 16] = stall_cnt;
`endif
  end

endmodule
